// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int unsigned CLA_GROUP     = 4;
  localparam int unsigned DEFAULT_WIDTH = 16;

  // Bits needed to hold values 0 .. value-1 (iteration counter width).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// A - B as A + ~B + 1, built from 4-bit carry-lookahead groups.
module cla_subtractor
  import div_pkg::*;
#(
  parameter int unsigned N = DEFAULT_WIDTH + 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int unsigned NG = N / CLA_GROUP;

  logic [N-1:0] gen;
  logic [N-1:0] prop;

  assign gen  = a & ~b;
  assign prop = a ^ ~b;

  always_comb begin
    logic [NG:0] grp_c;
    logic        grp_g;
    logic        grp_p;
    logic        c;
    int unsigned idx;
    diff     = '0;
    grp_c    = '0;
    grp_c[0] = 1'b1;
    // Group generate/propagate feed the group-carry chain; bit sums then use each group's carry-in.
    for (int unsigned k = 0; k < NG; k++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int unsigned j = 0; j < CLA_GROUP; j++) begin
        idx   = k * CLA_GROUP + j;
        grp_g = gen[idx] | (prop[idx] & grp_g);
        grp_p = grp_p & prop[idx];
      end
      grp_c[k+1] = grp_g | (grp_p & grp_c[k]);
    end
    for (int unsigned k = 0; k < NG; k++) begin
      c = grp_c[k];
      for (int unsigned j = 0; j < CLA_GROUP; j++) begin
        idx       = k * CLA_GROUP + j;
        diff[idx] = prop[idx] ^ c;
        c         = gen[idx] | (prop[idx] & c);
      end
    end
    borrow = ~grp_c[NG];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW    = clog2(WIDTH);
  localparam int unsigned SUB_W = WIDTH + 4;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;

  logic [WIDTH:0]   shifted;
  logic [SUB_W-1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             unused_bits;

  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  cla_subtractor #(.N(SUB_W)) u_sub (
    .a      ({3'b000, shifted}),
    .b      ({4'b0000, divisor_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_comb begin
    rem_next = borrow ? shifted : diff[WIDTH:0];
    quo_next = {quo_q[WIDTH-2:0], ~borrow};
  end

  assign unused_bits = ^{diff[SUB_W-1:WIDTH+1], rem_q[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              divisor_q   <= divisor;
              rem_q       <= '0;
              quo_q       <= dividend;
              count       <= CW'(WIDTH - 1);
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          count <= count - CW'(1);
          if (count == '0) begin
            quotient  <= quo_next;
            remainder <= rem_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed literal cases plus randomized traffic vs. an arithmetic model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference model: a division accepted at edge e finishes at edge e+W (e for divisor 0),
  // and the divider is free again two edges after that.
  longint       cyc     = 0;
  longint       acc_at  = -100;
  longint       done_at = -100;
  logic [W-1:0] m_q = '0, m_r = '0, pend_q = '0, pend_r = '0;
  bit           m_dz = 1'b0, pend_dz = 1'b0;
  int           accepts = 0, dut_dones = 0, exp_dones = 0;

  initial begin
    bit exp_busy, exp_done;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        acc_at  = -100;
        done_at = -100;
        m_q = '0; m_r = '0; m_dz = 1'b0;
      end else if (start && cyc > done_at + 1) begin
        accepts++;
        acc_at = cyc;
        if (divisor == '0) begin
          pend_q = '1; pend_r = dividend; pend_dz = 1'b1;
          done_at = cyc;
        end else begin
          pend_q = dividend / divisor; pend_r = dividend % divisor; pend_dz = 1'b0;
          m_dz = 1'b0;
          done_at = cyc + W;
        end
      end
      if (!rst && cyc == done_at) begin
        m_q = pend_q; m_r = pend_r; m_dz = pend_dz;
      end
      #1;
      exp_busy = (cyc >= acc_at) && (cyc <= done_at);
      exp_done = (cyc == done_at);
      if (exp_done) exp_dones++;
      if (done === 1'b1) dut_dones++;
      check(busy === exp_busy && done === exp_done && quotient === m_q &&
            remainder === m_r && div_by_zero === m_dz, "cycle_model",
            $sformatf("cyc=%0d got busy=%b done=%b q=%h r=%h dz=%b want busy=%b done=%b q=%h r=%h dz=%b",
                      cyc, busy, done, quotient, remainder, div_by_zero,
                      exp_busy, exp_done, m_q, m_r, m_dz));
    end
  end

  task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input int exp_lat,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz,
                        input string name);
    int n      = 0;
    int busy_n = 0;
    bit got    = 1'b0;
    @(negedge clk);
    dividend = dd; divisor = dv; start = 1'b1;
    while (!got && n < 40) begin
      @(posedge clk);
      #2;
      n++;
      if (n == 1) begin
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (busy) busy_n++;
      if (done) got = 1'b1;
    end
    check(got && n == exp_lat, {name, "_latency"},
          $sformatf("got done=%b after %0d edges, want after %0d", got, n, exp_lat));
    check(busy_n == exp_lat, {name, "_busy"},
          $sformatf("busy for %0d edges, want %0d", busy_n, exp_lat));
    check(quotient == eq && remainder == er && div_by_zero == edz, {name, "_result"},
          $sformatf("got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                    quotient, remainder, div_by_zero, eq, er, edz));
    @(posedge clk);
    #2;
  endtask

  initial begin
    int done_cnt;
    int sel;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check(busy == 1'b0 && done == 1'b0 && quotient == '0 && remainder == '0 && div_by_zero == 1'b0,
          "reset_state", $sformatf("got busy=%b done=%b q=%h r=%h dz=%b",
                                   busy, done, quotient, remainder, div_by_zero));

    do_div(16'd100,   16'd7, W + 1, 16'd14,    16'd2,    1'b0, "div_100_7");
    do_div(16'd65535, 16'd1, W + 1, 16'd65535, 16'd0,    1'b0, "div_65535_1");
    do_div(16'd5,     16'd9, W + 1, 16'd0,     16'd5,    1'b0, "div_5_9");
    do_div(16'd0,     16'd3, W + 1, 16'd0,     16'd0,    1'b0, "div_0_3");
    do_div(16'd1234,  16'd0, 1,     16'hFFFF,  16'd1234, 1'b1, "div_by_zero");
    do_div(16'd10,    16'd3, W + 1, 16'd3,     16'd1,    1'b0, "div_10_3");

    // A second start during CALC must be ignored entirely.
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check(quotient == 16'd14 && remainder == 16'd2, "ignored_start_result",
              $sformatf("got q=%0d r=%0d want q=14 r=2", quotient, remainder));
      end
    end
    check(done_cnt == 1, "ignored_start_done_count",
          $sformatf("got %0d done pulses, want 1", done_cnt));

    // Reset in the middle of a division, then restart immediately.
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    check(busy == 1'b0 && done == 1'b0 && quotient == '0 && remainder == '0 && div_by_zero == 1'b0,
          "mid_calc_reset", $sformatf("got busy=%b done=%b q=%h r=%h dz=%b",
                                      busy, done, quotient, remainder, div_by_zero));
    do_div(16'd1000, 16'd33, W + 1, 16'd30, 16'd10, 1'b0, "div_after_reset");

    // Random traffic: starts at arbitrary times (many land while busy), mixed operand classes, rare resets.
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      sel   = int'($urandom_range(0, 9));
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 1999) == 0);
      if (sel == 0) begin
        dividend = W'($urandom);
        divisor  = '0;
      end else if (sel <= 2) begin
        dividend = W'($urandom);
        divisor  = W'($urandom_range(1, 15));
      end else if (sel == 3) begin
        divisor  = W'($urandom_range(2, 65535));
        dividend = W'($urandom_range(0, int'(divisor) - 1));
      end else begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (W + 4) @(negedge clk);

    check(dut_dones == exp_dones, "done_pulse_count",
          $sformatf("got %0d done pulses, want %0d", dut_dones, exp_dones));
    check(accepts > 500, "random_activity",
          $sformatf("got %0d accepted starts, want more than 500", accepts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
